// File: rtl/wb_byte_mem_bridge.sv
// wb_byte_mem_bridge: serialises a 32-bit Wishbone access into big-endian byte accesses on a byte-wide memory.
module wb_byte_mem_bridge #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic          wb_ack_o,
  output logic [AW-1:0] mem_adr,
  output logic [7:0]    mem_dat_o,
  input  logic [7:0]    mem_dat_i,
  output logic          mem_we,
  output logic          mem_en
);
  typedef enum logic [1:0] {IDLE, ACCESS, RD_LAST, ACK} state_t;
  state_t state, state_n;
  logic [AW-3:0] base_q;
  logic [31:0] dat_q;
  logic [3:0] rem_q, rem_n;
  logic [1:0] off_q, cur_off, lane;
  logic we_q, rd_pend, req, issue;
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:AW], wb_adr_i[1:0]};
  assign req = state == IDLE && wb_cyc_i && wb_stb_i;
  assign issue = state == ACCESS && wb_cyc_i;
  // Lowest offset first: sel[3] is offset 0.
  assign cur_off = rem_q[3] ? 2'd0 : rem_q[2] ? 2'd1 : rem_q[1] ? 2'd2 : 2'd3;
  assign rem_n = rem_q & ~(4'b1000 >> cur_off);
  assign lane = state == ACCESS ? cur_off : off_q;
  assign mem_adr = {base_q, lane};
  assign mem_dat_o = dat_q[{~lane, 3'b000} +: 8];
  assign mem_en = (state == ACCESS || state == RD_LAST) && wb_cyc_i;
  assign mem_we = state == ACCESS && we_q;
  assign wb_ack_o = state == ACK;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req) state_n = wb_sel_i == 4'd0 ? ACK : ACCESS;
      ACCESS:  if (!wb_cyc_i) state_n = IDLE;
               else if (rem_n == 4'd0) state_n = we_q ? ACK : RD_LAST;
      RD_LAST: state_n = wb_cyc_i ? ACK : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base_q <= '0;
      dat_q <= '0;
      rem_q <= '0;
      off_q <= '0;
      we_q <= 1'b0;
      rd_pend <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state <= state_n;
      rd_pend <= issue && !we_q;
      if (req) begin
        base_q <= wb_adr_i[AW-1:2];
        dat_q <= wb_dat_i;
        rem_q <= wb_sel_i;
        we_q <= wb_we_i;
        if (!wb_we_i) wb_dat_o <= '0;
      end
      if (issue) begin
        rem_q <= rem_n;
        off_q <= cur_off;
      end
      // Memory returns the byte one cycle after the access was issued.
      if (rd_pend && wb_cyc_i) wb_dat_o[{~off_q, 3'b000} +: 8] <= mem_dat_i;
    end
  end
endmodule

// File: tb/tb_wb_byte_mem_bridge.sv
// tb_wb_byte_mem_bridge: directed table, random transactions and corner sequences for wb_byte_mem_bridge.
module tb_wb_byte_mem_bridge;
  localparam int AW = 14;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0] wb_sel_i = '0;
  logic wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_ack_o;
  logic [AW-1:0] mem_adr;
  logic [7:0] mem_dat_o, mem_dat_i;
  logic mem_we, mem_en;
  always #5 clk = ~clk;
  wb_byte_mem_bridge #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .mem_adr(mem_adr), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_we(mem_we), .mem_en(mem_en)
  );
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];
  logic [AW+7:0] wlog [$];
  always @(posedge clk) begin
    mem_dat_i <= mem_en ? mem[mem_adr] : 8'h00;
    if (mem_en && mem_we) begin
      mem[mem_adr] <= mem_dat_o;
      wlog.push_back({mem_adr, mem_dat_o});
    end
  end
  int total = 0, bad = 0;
  logic [31:0] held = '0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic logic [AW-1:0] badr(input logic [31:0] adr, input int off);
    logic [1:0] o;
    o = off[1:0];
    return {adr[AW-1:2], o};
  endfunction
  function automatic logic [31:0] model_rd(input logic [31:0] adr, input logic [3:0] sel);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (sel[3-i]) r[8*(3-i) +: 8] = ref_mem[badr(adr, i)];
    return r;
  endfunction
  function automatic int model_ack(input logic [3:0] sel, input logic we);
    return sel == 4'd0 ? 1 : $countones(sel) + (we ? 1 : 2);
  endfunction
  function automatic int model_en(input logic [3:0] sel, input logic we);
    return sel == 4'd0 ? 0 : $countones(sel) + (we ? 0 : 1);
  endfunction
  task automatic txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic we,
                     input int abort_at, output int ack_cyc, output int en_cnt, output int acks);
    @(negedge clk);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    ack_cyc = -1; en_cnt = 0; acks = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; #1;
      end
      if (wb_ack_o) begin
        acks++;
        if (ack_cyc < 0) ack_cyc = c;
      end
      if (mem_en) en_cnt++;
      if (ack_cyc > 0 || (abort_at > 0 && c >= abort_at)) break;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    if (wb_ack_o) acks++;
  endtask
  task automatic run(input string tag, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic we, input int eack, input int een, input logic [31:0] erd);
    logic [AW+7:0] ew [$];
    int ack_cyc, en_cnt, acks;
    for (int i = 0; i < 4; i++) if (we && sel[3-i]) ew.push_back({badr(adr, i), dat[8*(3-i) +: 8]});
    wlog.delete();
    txn(adr, dat, sel, we, 0, ack_cyc, en_cnt, acks);
    chk({tag, " ack_cycle"}, ack_cyc, eack);
    chk({tag, " ack_count"}, acks, 1);
    chk({tag, " en_cycles"}, en_cnt, een);
    chk({tag, " rdata"}, wb_dat_o, erd);
    chk({tag, " nwrites"}, wlog.size(), ew.size());
    if (wlog.size() == ew.size())
      for (int i = 0; i < ew.size(); i++) chk({tag, " write"}, 32'(wlog[i]), 32'(ew[i]));
    for (int i = 0; i < ew.size(); i++) ref_mem[ew[i][AW+7:8]] = ew[i][7:0];
  endtask
  typedef struct {
    logic [31:0] adr, dat;
    logic [3:0] sel;
    logic we;
    int ack, en;
    logic [31:0] rd;
  } vec_t;
  vec_t v [8];
  initial begin
    int ack_cyc, en_cnt, acks;
    logic [31:0] a, d;
    logic [3:0] s;
    logic w;
    v[0] = '{32'h0104, 32'hDEADBEEF, 4'hF, 1'b1, 5, 4, 32'h0};
    v[1] = '{32'h0104, 32'h0, 4'hF, 1'b0, 6, 5, 32'hDEADBEEF};
    v[2] = '{32'h0104, 32'h0, 4'h2, 1'b0, 3, 2, 32'h0000BE00};
    v[3] = '{32'h0200, 32'h12345678, 4'h0, 1'b1, 1, 0, 32'h0000BE00};
    v[4] = '{32'h0104, 32'h0, 4'h0, 1'b0, 1, 0, 32'h0};
    v[5] = '{32'h3FFC, 32'h11223344, 4'h9, 1'b1, 3, 2, 32'h0};
    v[6] = '{32'hFFFF3FFC, 32'h0, 4'hF, 1'b0, 6, 5, 32'h11000044};
    v[7] = '{32'h0104, 32'h0, 4'h5, 1'b0, 4, 3, 32'h00AD00EF};
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", wb_ack_o, 0);
    chk("reset en", mem_en, 0);
    chk("reset we", mem_we, 0);
    chk("reset rdata", wb_dat_o, 0);
    chk("reset adr", mem_adr, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      run($sformatf("vec%0d", i), v[i].adr, v[i].dat, v[i].sel, v[i].we, v[i].ack, v[i].en, v[i].rd);
    held = v[7].rd;
    wlog.delete();
    txn(32'h0104, 32'hA1B2C3D4, 4'hF, 1'b1, 2, ack_cyc, en_cnt, acks);
    chk("abort ack_count", acks, 0);
    chk("abort ack_cycle", ack_cyc, -1);
    chk("abort en_cycles", en_cnt, 1);
    chk("abort nwrites", wlog.size(), 1);
    if (wlog.size() == 1) chk("abort write", 32'(wlog[0]), 32'({14'h0104, 8'hA1}));
    ref_mem[14'h0104] = 8'hA1;
    run("after_abort", 32'h0104, 32'h0, 4'hF, 1'b0, 6, 5, 32'hA1ADBEEF);
    held = 32'hA1ADBEEF;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom & 32'hFFFF_C000) | (32'h1000 + 4 * $urandom_range(0, 7)) | 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom);
      w = 1'($urandom);
      if (!w) held = model_rd(a, s);
      run($sformatf("rnd%0d", n), a, d, s, w, model_ack(s, w), model_en(s, w), held);
    end
    @(negedge clk);
    wb_adr_i = 32'h0104; wb_sel_i = 4'hF; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; #1;
    chk("rst_mid ack", wb_ack_o, 0);
    chk("rst_mid rdata", wb_dat_o, 0);
    chk("rst_mid en", mem_en, 0);
    chk("rst_mid we", mem_we, 0);
    chk("rst_mid adr", mem_adr, 0);
    chk("rst_mid wdata", mem_dat_o, 0);
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (wb_ack_o || mem_en) acks++;
    end
    chk("rst_mid quiet", acks, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
